// File: rtl/kan_pkg.sv
// kan_pkg: shared FSM states, error codes and descriptor layout for the KAN layer sequencer.
package kan_pkg;
  localparam int KAN_ADDRWIDTH = 32;
  localparam int KAN_LG_LAYERSIZE = 12;
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LOAD, S_CLEAR, S_START, S_RUN, S_DONE, S_ERR
  } state_t;
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DESC  = 2'd1;
  localparam logic [1:0] ERR_WDOG  = 2'd2;
  localparam logic [1:0] ERR_COUNT = 2'd3;
  typedef struct packed {
    logic [KAN_ADDRWIDTH-1:0]    base;
    logic [KAN_ADDRWIDTH-1:0]    zero;
    logic [KAN_LG_LAYERSIZE-1:0] in_size;
    logic [KAN_LG_LAYERSIZE-1:0] out_size;
  } desc_t;
endpackage

// File: rtl/kan_desc_table.sv
// kan_desc_table: per-layer descriptor register file, one write port, one registered read port.
module kan_desc_table #(
  parameter int W = 88,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rd_q;
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end
  assign rd_data = rd_q;
endmodule

// File: rtl/kan_layer_sequencer.sv
// kan_layer_sequencer: steps the loader/kernel datapath through a table of layer descriptors,
// with a per-layer clear, start pulse, tlast completion watch and watchdog.
module kan_layer_sequencer
  import kan_pkg::*;
#(
  parameter int ADDRWIDTH     = 32,
  parameter int LG_LAYERSIZE  = 12,
  parameter int LG_MAX_LAYERS = 3,
  parameter int CLEAR_CYCLES  = 2,
  parameter int WATCHDOG      = 65535
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_areset,
  input  logic                      cfg_we,
  input  logic [LG_MAX_LAYERS-1:0]  cfg_addr,
  input  logic [ADDRWIDTH-1:0]      cfg_base_address,
  input  logic [ADDRWIDTH-1:0]      cfg_zero_address,
  input  logic [LG_LAYERSIZE-1:0]   cfg_in_size,
  input  logic [LG_LAYERSIZE-1:0]   cfg_out_size,
  input  logic [LG_MAX_LAYERS:0]    cfg_num_layers,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                err_code,
  output logic [ADDRWIDTH-1:0]      base_address,
  output logic [ADDRWIDTH-1:0]      zero_address,
  output logic [LG_LAYERSIZE-1:0]   input_layersize,
  output logic [LG_LAYERSIZE-1:0]   output_layersize,
  output logic [LG_LAYERSIZE+2:0]   kernel_input_count,
  output logic                      datapath_rst,
  output logic                      layer_start,
  output logic [LG_MAX_LAYERS-1:0]  layer_idx,
  input  logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic                      m_axis_tlast
);
  localparam int DW = 2 * ADDRWIDTH + 2 * LG_LAYERSIZE;
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam int WW = $clog2(WATCHDOG + 1);
  localparam int KW = LG_LAYERSIZE + 3;
  localparam logic [LG_MAX_LAYERS:0] MAXL = (LG_MAX_LAYERS + 1)'(2 ** LG_MAX_LAYERS);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [WW-1:0] WD_INIT = WW'(WATCHDOG);
  state_t state_q, state_d;
  logic [LG_MAX_LAYERS:0] num_q, num_d;
  logic [LG_MAX_LAYERS-1:0] idx_q, idx_d;
  logic [CW-1:0] clr_q, clr_d;
  logic [WW-1:0] wd_q, wd_d;
  logic error_q, error_d;
  logic [1:0] code_q, code_d;
  logic [ADDRWIDTH-1:0] base_q, base_d, zero_q, zero_d;
  logic [LG_LAYERSIZE-1:0] in_q, in_d, out_q, out_d;
  logic [KW-1:0] kic_q, kic_d;
  logic [DW-1:0] rd_data;
  logic [ADDRWIDTH-1:0] rd_base, rd_zero;
  logic [LG_LAYERSIZE-1:0] rd_in, rd_out;
  logic desc_ok, beat, last_layer;
  assign {rd_base, rd_zero, rd_in, rd_out} = rd_data;
  assign desc_ok = rd_in != '0 && rd_out != '0 && rd_in[1:0] == 2'b00 && rd_out[1:0] == 2'b00;
  assign beat = m_axis_tvalid && m_axis_tready;
  assign last_layer = ((LG_MAX_LAYERS + 1)'(idx_q) + (LG_MAX_LAYERS + 1)'(1)) == num_q;
  // Read address follows the next index so the descriptor is already registered when LOAD is reached.
  kan_desc_table #(.W(DW), .AW(LG_MAX_LAYERS)) u_table (
    .clk    (s_axis_aclk),
    .we     (cfg_we && state_q == S_IDLE),
    .wr_addr(cfg_addr),
    .wr_data({cfg_base_address, cfg_zero_address, cfg_in_size, cfg_out_size}),
    .rd_addr(idx_d),
    .rd_data(rd_data)
  );
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    idx_d = idx_q;
    clr_d = clr_q;
    wd_d = wd_q;
    error_d = error_q;
    code_d = code_q;
    base_d = base_q;
    zero_d = zero_q;
    in_d = in_q;
    out_d = out_q;
    kic_d = kic_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CHECK;
        num_d = cfg_num_layers;
        error_d = 1'b0;
        code_d = ERR_NONE;
        idx_d = '0;
      end
      S_CHECK: begin
        state_d = num_q == '0 ? S_DONE : num_q > MAXL ? S_ERR : S_LOAD;
        error_d = num_q > MAXL;
        code_d = num_q > MAXL ? ERR_COUNT : ERR_NONE;
      end
      S_LOAD: if (!desc_ok) begin
        state_d = S_ERR;
        error_d = 1'b1;
        code_d = ERR_DESC;
      end else begin
        state_d = S_CLEAR;
        base_d = rd_base;
        zero_d = rd_zero;
        in_d = rd_in;
        out_d = rd_out;
        kic_d = KW'({rd_in, 2'b00}) + KW'(rd_in);
        clr_d = CLR_LAST;
      end
      S_CLEAR: begin
        state_d = clr_q == '0 ? S_START : S_CLEAR;
        clr_d = clr_q == '0 ? clr_q : clr_q - CW'(1);
      end
      S_START: begin
        state_d = S_RUN;
        wd_d = WD_INIT;
      end
      S_RUN: if (beat && m_axis_tlast) begin
        idx_d = idx_q + LG_MAX_LAYERS'(1);
        state_d = last_layer ? S_DONE : S_LOAD;
      end else if (beat) begin
        wd_d = WD_INIT;
      end else if (wd_q == WW'(1)) begin
        state_d = S_ERR;
        error_d = 1'b1;
        code_d = ERR_WDOG;
      end else begin
        wd_d = wd_q - WW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q <= S_IDLE;
      num_q <= '0;
      idx_q <= '0;
      clr_q <= '0;
      wd_q <= '0;
      error_q <= 1'b0;
      code_q <= ERR_NONE;
      base_q <= '0;
      zero_q <= '0;
      in_q <= '0;
      out_q <= '0;
      kic_q <= '0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      idx_q <= idx_d;
      clr_q <= clr_d;
      wd_q <= wd_d;
      error_q <= error_d;
      code_q <= code_d;
      base_q <= base_d;
      zero_q <= zero_d;
      in_q <= in_d;
      out_q <= out_d;
      kic_q <= kic_d;
    end
  end
  assign busy = state_q != S_IDLE && state_q != S_DONE;
  assign done = state_q == S_DONE;
  assign layer_start = state_q == S_START;
  assign datapath_rst = !(state_q == S_START || state_q == S_RUN);
  assign error = error_q;
  assign err_code = code_q;
  assign layer_idx = idx_q;
  assign base_address = base_q;
  assign zero_address = zero_q;
  assign input_layersize = in_q;
  assign output_layersize = out_q;
  assign kernel_input_count = kic_q;
endmodule

// File: tb/tb_kan_layer_sequencer.sv
// tb_kan_layer_sequencer: randomized runs against a descriptor-level model, checked by a scoreboard monitor.
module tb_kan_layer_sequencer;
  import kan_pkg::*;
  localparam int CC = 2;
  localparam int WD = 16;
  localparam int EV_LS = 0, EV_DONE = 1, EV_ERR = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_we = 1'b0, start = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [31:0] cfg_base = '0, cfg_zero = '0;
  logic [11:0] cfg_in = '0, cfg_out = '0;
  logic [3:0] cfg_num = '0;
  logic tvalid = 1'b0, tready = 1'b0, tlast = 1'b0;
  logic busy, done, error, datapath_rst, layer_start;
  logic [1:0] err_code;
  logic [31:0] base_address, zero_address;
  logic [11:0] input_layersize, output_layersize;
  logic [14:0] kernel_input_count;
  logic [2:0] layer_idx;
  typedef struct {
    int kind;
    int delta;
    int idx;
    desc_t d;
    int code;
  } ev_t;
  ev_t exp_q[$];
  desc_t tbl[8];
  int n_cmp = 0, n_bad = 0, cyc = 0, ref_edge = 0;
  kan_layer_sequencer #(.CLEAR_CYCLES(CC), .WATCHDOG(WD)) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_base_address(cfg_base), .cfg_zero_address(cfg_zero), .cfg_in_size(cfg_in),
    .cfg_out_size(cfg_out), .cfg_num_layers(cfg_num), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .base_address(base_address), .zero_address(zero_address),
    .input_layersize(input_layersize), .output_layersize(output_layersize),
    .kernel_input_count(kernel_input_count), .datapath_rst(datapath_rst),
    .layer_start(layer_start), .layer_idx(layer_idx), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic desc_t mk(logic [31:0] b, logic [31:0] z, int i, int o);
    desc_t d;
    d.base = b;
    d.zero = z;
    d.in_size = 12'(i);
    d.out_size = 12'(o);
    return d;
  endfunction
  function automatic desc_t rand_valid();
    return mk($urandom, $urandom, 4 * $urandom_range(1, 1023), 4 * $urandom_range(1, 1023));
  endfunction
  function automatic bit valid(desc_t d);
    return d.in_size != 0 && d.out_size != 0 && d.in_size % 4 == 0 && d.out_size % 4 == 0;
  endfunction
  function automatic void push(int kind, int delta, int idx, desc_t d, int code);
    ev_t e;
    e.kind = kind;
    e.delta = delta;
    e.idx = idx;
    e.d = d;
    e.code = code;
    exp_q.push_back(e);
  endfunction
  // Expected event sequence of one run; returns how many layers get a layer_start.
  // mode 0: normal, 1: stream stalls on layer sl, 2: tlast lands on watchdog expiry of layer sl.
  function automatic int plan(int n, int mode, int sl, output bit fails);
    desc_t none = mk(0, 0, 0, 0);
    fails = 1'b1;
    if (n == 0) begin
      fails = 1'b0;
      push(EV_DONE, 1, 0, none, 0);
      return 0;
    end
    if (n > 8) begin
      push(EV_ERR, 1, 0, none, 3);
      return 0;
    end
    for (int i = 0; i < n; i++) begin
      if (!valid(tbl[i])) begin
        push(EV_ERR, i == 0 ? 2 : 1, i, none, 1);
        return i;
      end
      push(EV_LS, i == 0 ? 2 + CC : 1 + CC, i, tbl[i], 0);
      if (mode == 1 && i == sl) begin
        push(EV_ERR, WD + 1, i, none, 2);
        return i + 1;
      end
    end
    fails = 1'b0;
    push(EV_DONE, 0, n % 8, none, 0);
    return n;
  endfunction
  initial begin
    ev_t e;
    int cur;
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (layer_start || done || (error && !err_prev))) begin
        cur = layer_start ? EV_LS : done ? EV_DONE : EV_ERR;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 64'(cur), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", 64'(cur), 64'(e.kind));
          chk("event_latency", 64'(cyc - ref_edge), 64'(e.delta));
          chk("layer_idx", 64'(layer_idx), 64'(e.idx));
          if (e.kind == EV_LS) begin
            chk("base_address", 64'(base_address), 64'(e.d.base));
            chk("zero_address", 64'(zero_address), 64'(e.d.zero));
            chk("input_layersize", 64'(input_layersize), 64'(e.d.in_size));
            chk("output_layersize", 64'(output_layersize), 64'(e.d.out_size));
            chk("kernel_input_count", 64'(kernel_input_count), 64'(int'(e.d.in_size) * 5));
            chk("rst_low_at_start", 64'(datapath_rst), 64'(0));
            chk("busy_at_start", 64'(busy), 64'(1));
            ref_edge = cyc;
          end else if (e.kind == EV_DONE) begin
            chk("busy_at_done", 64'(busy), 64'(0));
            chk("error_at_done", 64'(error), 64'(0));
          end else begin
            chk("err_code", 64'(err_code), 64'(e.code));
            chk("rst_in_err", 64'(datapath_rst), 64'(1));
          end
        end
      end
      err_prev = error;
    end
  end
  task automatic beat_cycle(logic v, logic r, logic l);
    tvalid = v;
    tready = r;
    tlast = l;
    @(negedge clk);
    tvalid = 1'b0;
    tready = 1'b0;
    tlast = 1'b0;
  endtask
  task automatic write_desc(int a, desc_t d);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_base = d.base;
    cfg_zero = d.zero;
    cfg_in = d.in_size;
    cfg_out = d.out_size;
    @(negedge clk);
    cfg_we = 1'b0;
    tbl[a] = d;
  endtask
  task automatic wait_ls(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (layer_start) begin
        got = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask
  task automatic check_reset_vals();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_err_code", 64'(err_code), 0);
    chk("rst_datapath_rst", 64'(datapath_rst), 1);
    chk("rst_layer_start", 64'(layer_start), 0);
    chk("rst_layer_idx", 64'(layer_idx), 0);
    chk("rst_cfg_outputs", {base_address, zero_address}, 0);
    chk("rst_sizes", 64'({input_layersize, output_layersize, kernel_input_count}), 0);
  endtask
  task automatic run(int n, int mode, int sl, bit poke, int nb_fixed, bit abort);
    int ns, nb;
    bit fails, got;
    ns = plan(n, mode, sl, fails);
    cfg_num = 4'(n);
    start = 1'b1;
    ref_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < ns; i++) begin
      wait_ls(got);
      if (!got) begin
        chk("layer_start_timeout", 0, 1);
        break;
      end
      beat_cycle(1'b0, 1'b0, 1'b0);
      if (abort) begin
        beat_cycle(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      if (poke && i == 0) begin
        start = 1'b1;
        cfg_num = 4'd1;
        cfg_we = 1'b1;
        cfg_addr = 3'd0;
        cfg_base = 32'hDEAD0000;
        cfg_zero = 32'hBEEF0000;
        cfg_in = 12'd40;
        cfg_out = 12'd44;
        beat_cycle(1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cfg_we = 1'b0;
      end
      if (mode == 1 && i == sl) begin
      end else if (mode == 2 && i == sl) begin
        repeat (WD - 1) beat_cycle(1'b0, 1'b0, 1'b0);
        ref_edge = cyc + 1;
        beat_cycle(1'b1, 1'b1, 1'b1);
      end else begin
        nb = nb_fixed > 0 ? nb_fixed : $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin
          repeat ($urandom_range(0, 3)) beat_cycle(1'($urandom), 1'b0, 1'b0);
          if (b == nb - 1) ref_edge = cyc + 1;
          beat_cycle(1'b1, 1'b1, b == nb - 1);
        end
      end
    end
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done || error) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("run_end_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("busy_after_run", 64'(busy), 0);
    chk("error_after_run", 64'(error), 64'(fails));
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    write_desc(0, mk(32'h80000, 32'h70000, 12, 16));
    write_desc(1, mk(32'h90000, 32'h70000, 16, 8));
    write_desc(2, mk($urandom, $urandom, 4092, 4));
    for (int i = 3; i < 8; i++) write_desc(i, rand_valid());
    run(2, 0, 0, 0, 4, 0);
    run(0, 0, 0, 0, 0, 0);
    run(9, 0, 0, 0, 0, 0);
    run(3, 0, 0, 0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      write_desc($urandom_range(2, 7), rand_valid());
      run($urandom_range(1, 8), 0, 0, 0, 0, 0);
    end
    write_desc(1, mk(32'h90000, 32'h70000, 10, 8));
    run(2, 0, 0, 0, 4, 0);
    for (int r = 0; r < 3; r++) begin
      int j;
      desc_t keep;
      j = $urandom_range(0, 3);
      keep = tbl[j];
      write_desc(j, mk($urandom, $urandom, r == 0 ? 0 : 4 * $urandom_range(1, 100), r == 1 ? 4 * $urandom_range(1, 100) + r : 4 * $urandom_range(1, 100) + 2));
      run($urandom_range(j + 1, 8), 0, 0, 0, 0, 0);
      write_desc(j, keep);
    end
    write_desc(1, mk(32'h90000, 32'h70000, 16, 8));
    run(1, 1, 0, 0, 0, 0);
    run(2, 1, 1, 0, 0, 0);
    run(1, 2, 0, 0, 0, 0);
    run(2, 0, 0, 1, 0, 0);
    run(2, 0, 0, 0, 4, 0);
    run(2, 0, 0, 0, 0, 1);
    run(2, 0, 0, 0, 4, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
